// File: rtl/scara_fx_pkg.sv
// rtl/scara_fx_pkg.sv - shared types and fixed-point helpers for the SCARA kinematics blocks
package scara_fx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROD,
    ST_SUM,
    ST_CHECK,
    ST_DIV,
    ST_DONE
  } state_e;

  // +1.0 or -1.0 with frac fractional bits; callers size-cast to their Q1.frac width
  function automatic logic signed [31:0] fx_one(input int frac, input logic neg);
    logic signed [31:0] one;
    one = 32'sd1 <<< frac;
    return neg ? -one : one;
  endfunction

endpackage

// File: rtl/fixed_div_seq.sv
// rtl/fixed_div_seq.sv - restoring divider, one quotient bit per cycle
module fixed_div_seq #(
  parameter int VW    = 49,
  parameter int QBITS = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [QBITS+VW-1:0]   dividend,
  input  logic [VW-1:0]         divisor,
  output logic                  done,
  output logic [QBITS-1:0]      quotient
);

  localparam int CW = $clog2(QBITS) + 1;

  logic [VW-1:0]    rem_q, rem_d;
  logic [VW-1:0]    dvs_q, dvs_d;
  logic [QBITS-1:0] shr_q, shr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [VW:0]      trial;
  logic             fits;

  // shr_q holds unconsumed dividend bits at the top and quotient bits filling from the bottom;
  // the top dividend bits must already be below the divisor, so QBITS steps give the full quotient
  always_comb begin
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    shr_d    = shr_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    trial    = {rem_q, shr_q[QBITS-1]};
    fits     = trial >= {1'b0, dvs_q};
    quotient = {shr_q[QBITS-2:0], fits};
    done     = run_q && (cnt_q == CW'(QBITS - 1));
    if (start) begin
      rem_d = dividend[QBITS +: VW];
      shr_d = dividend[QBITS-1:0];
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = fits ? VW'(trial - {1'b0, dvs_q}) : trial[VW-1:0];
      shr_d = quotient;
      cnt_d = cnt_q + CW'(1);
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      dvs_q <= '0;
      shr_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      shr_q <= shr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/cosine_th2_fx.sv
// rtl/cosine_th2_fx.sv - cos(theta2) = (x^2+y^2-l1^2-l2^2)/(2*l1*l2) for a two-link arm
module cosine_th2_fx
  import scara_fx_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int FRAC  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  x_target,
  input  logic [WIDTH-1:0]  y_target,
  input  logic [WIDTH-1:0]  l1,
  input  logic [WIDTH-1:0]  l2,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FRAC+1:0]   cos_th2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              reach_err,
  output logic              div_zero,
  output logic              busy
);

  localparam int PW = 2 * WIDTH;
  localparam int NW = 2 * WIDTH + 2;
  localparam int DN = 2 * WIDTH + 1;
  localparam int OW = FRAC + 2;
  localparam int QB = FRAC + 1;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0]        l1_q, l1_d, l2_q, l2_d;
  logic signed [PW-1:0]    xx_q, xx_d, yy_q, yy_d;
  logic [PW-1:0]           aa_q, aa_d, bb_q, bb_d, ab_q, ab_d;
  logic signed [NW-1:0]    num_q, num_d;
  logic [DN-1:0]           den_q, den_d;
  logic [OW-1:0]           cos_q, cos_d;
  logic                    reach_q, reach_d, dz_q, dz_d, ov_q, ov_d;

  logic signed [PW-1:0]    x_ext, y_ext;
  logic [PW-1:0]           a_ext, b_ext;
  logic [NW-1:0]           num_abs;
  logic [OW-1:0]           div_mag;
  logic                    div_start, div_done;
  logic [QB-1:0]           div_quot;

  fixed_div_seq #(
    .VW    (DN),
    .QBITS (QB)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend ({num_abs, {FRAC{1'b0}}}),
    .divisor  (den_q),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    l1_d      = l1_q;
    l2_d      = l2_q;
    xx_d      = xx_q;
    yy_d      = yy_q;
    aa_d      = aa_q;
    bb_d      = bb_q;
    ab_d      = ab_q;
    num_d     = num_q;
    den_d     = den_q;
    cos_d     = cos_q;
    reach_d   = reach_q;
    dz_d      = dz_q;
    ov_d      = ov_q;
    div_start = 1'b0;
    x_ext     = PW'(x_q);
    y_ext     = PW'(y_q);
    a_ext     = PW'(l1_q);
    b_ext     = PW'(l2_q);
    num_abs   = num_q[NW-1] ? -num_q : num_q;
    div_mag   = {1'b0, div_quot};

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x_target;
          y_d     = y_target;
          l1_d    = l1;
          l2_d    = l2;
          reach_d = 1'b0;
          dz_d    = 1'b0;
          state_d = ST_PROD;
        end
      end
      ST_PROD: begin
        xx_d    = x_ext * x_ext;
        yy_d    = y_ext * y_ext;
        aa_d    = a_ext * a_ext;
        bb_d    = b_ext * b_ext;
        ab_d    = a_ext * b_ext;
        state_d = ST_SUM;
      end
      ST_SUM: begin
        num_d   = {{2{xx_q[PW-1]}}, xx_q} + {{2{yy_q[PW-1]}}, yy_q}
                - {2'b00, aa_q} - {2'b00, bb_q};
        den_d   = {ab_q, 1'b0};
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (den_q == '0) begin
          dz_d    = 1'b1;
          cos_d   = '0;
          ov_d    = 1'b1;
          state_d = ST_DONE;
        end else if (num_abs > {1'b0, den_q}) begin
          reach_d = 1'b1;
          cos_d   = OW'(fx_one(FRAC, num_q[NW-1]));
          ov_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        // last quotient bit arrives combinationally so DONE lands on the same edge
        if (div_done) begin
          cos_d   = num_q[NW-1] ? -div_mag : div_mag;
          ov_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
      xx_q    <= '0;
      yy_q    <= '0;
      aa_q    <= '0;
      bb_q    <= '0;
      ab_q    <= '0;
      num_q   <= '0;
      den_q   <= '0;
      cos_q   <= '0;
      reach_q <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      xx_q    <= xx_d;
      yy_q    <= yy_d;
      aa_q    <= aa_d;
      bb_q    <= bb_d;
      ab_q    <= ab_d;
      num_q   <= num_d;
      den_q   <= den_d;
      cos_q   <= cos_d;
      reach_q <= reach_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = ov_q;
  assign cos_th2   = cos_q;
  assign reach_err = reach_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_cosine_th2_fx.sv
// tb/tb_cosine_th2_fx.sv - randomized bench for cosine_th2_fx against an arithmetic reference
module tb_cosine_th2_fx;

  localparam int W = 24;
  localparam int F = 16;
  localparam logic [W-1:0] ONE = 24'h010000;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   x_target, y_target, l1, l2;
  logic           in_valid, in_ready;
  logic [F+1:0]   cos_th2;
  logic           out_valid, out_ready, reach_err, div_zero, busy;

  cosine_th2_fx #(.WIDTH(W), .FRAC(F)) dut (
    .clk       (clk),
    .reset     (reset),
    .x_target  (x_target),
    .y_target  (y_target),
    .l1        (l1),
    .l2        (l2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cos_th2   (cos_th2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .reach_err (reach_err),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [F+1:0] cos;
    logic         re;
    logic         dz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   or_mode = 0;
  bit   seen_first = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [F+1:0] cos, output logic re,
                                output logic dz, output int lat);
    logic signed [127:0] xs, ys, as_, bs, num, den, an, q, one;
    xs  = {{104{x[W-1]}}, x};
    ys  = {{104{y[W-1]}}, y};
    as_ = {104'b0, a};
    bs  = {104'b0, b};
    num = xs * xs + ys * ys - as_ * as_ - bs * bs;
    den = 2 * as_ * bs;
    re  = 1'b0;
    dz  = 1'b0;
    one = 128'sd1 <<< F;
    if (den == 0) begin
      dz  = 1'b1;
      q   = 0;
      lat = 3;
    end else begin
      an = (num < 0) ? -num : num;
      if (an > den) begin
        re  = 1'b1;
        q   = (num < 0) ? -one : one;
        lat = 3;
      end else begin
        q = (an <<< F) / den;
        if (num < 0) q = -q;
        lat = 4 + F;
      end
    end
    cos = q[F+1:0];
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // every cycle a result is presented it must equal the oldest outstanding expectation
  initial forever begin
    @(negedge clk);
    if (reset === 1'b0) begin
      chk("in_ready_vs_busy", in_ready, !busy);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          chk("cos_th2", cos_th2, exp_q[0].cos);
          chk("reach_err", reach_err, exp_q[0].re);
          chk("div_zero", div_zero, exp_q[0].dz);
          chk("in_ready_in_done", in_ready, 1'b0);
          if (!seen_first) begin
            chk("latency", cycle - exp_q[0].acc, exp_q[0].lat);
            seen_first = 1;
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            seen_first = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   rdy;
    int   n;
    x_target = x;
    y_target = y;
    l1       = a;
    l2       = b;
    in_valid = 1'b1;
    n = 0;
    do begin
      rdy = in_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!rdy && n < 500);
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept t=%0t", $time);
    end else begin
      model(x, y, a, b, e.cos, e.re, e.dz, e.lat);
      e.acc = cycle;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 pending results", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic pin(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [F+1:0] rc, input logic rre, input logic rdz, input int rlat);
    logic [F+1:0] c;
    logic         re, dz;
    int           lat;
    model(x, y, a, b, c, re, dz, lat);
    chk({name, "_cos"}, c, rc);
    chk({name, "_flags"}, {re, dz}, {rre, rdz});
    chk({name, "_lat"}, lat, rlat);
  endtask

  function automatic logic [W-1:0] rnd_pos(input int hi);
    return W'($urandom_range(0, hi));
  endfunction

  function automatic logic [W-1:0] rnd_signed(input int span);
    int v;
    v = int'($urandom_range(0, 2 * span)) - span;
    return W'(v);
  endfunction

  initial begin
    int acc;
    int n;
    logic [W-1:0] x, y, a, b;

    reset    = 1'b1;
    in_valid = 1'b0;
    x_target = '0;
    y_target = '0;
    l1       = '0;
    l2       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cos", cos_th2, '0);
    chk("rst_flags", {reach_err, div_zero}, 2'b00);
    reset = 1'b0;
    @(negedge clk);

    pin("pin_zero",   ONE,          ONE, ONE, ONE, 18'h00000, 1'b0, 1'b0, 20);
    pin("pin_eighth", 24'h018000,   '0,  ONE, ONE, 18'h02000, 1'b0, 1'b0, 20);
    pin("pin_plus1",  24'h020000,   '0,  ONE, ONE, 18'h10000, 1'b0, 1'b0, 20);
    pin("pin_minus1", '0,           '0,  ONE, ONE, 18'h30000, 1'b0, 1'b0, 20);
    pin("pin_clamp",  24'h030000,   '0,  ONE, ONE, 18'h10000, 1'b1, 1'b0, 3);
    pin("pin_divz",   24'h012345,   ONE, '0,  ONE, 18'h00000, 1'b0, 1'b1, 3);

    send(ONE, ONE, ONE, ONE);               drain();
    send(24'h018000, '0, ONE, ONE);         drain();
    send(24'h020000, '0, ONE, ONE);         drain();
    send('0, '0, ONE, ONE);                 drain();
    send(24'h030000, '0, ONE, ONE);         drain();
    send(24'h012345, ONE, '0, ONE);         drain();
    send(24'hFD0000, 24'h001000, ONE, ONE); drain();

    // held result plus a waiting operand that must not slip in early
    or_mode = 2;
    send(24'h018000, '0, ONE, ONE);
    x_target = 24'h020000;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", out_valid, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_cos", cos_th2, 18'h02000);
    end
    or_mode = 0;
    n = 0;
    while (!(out_valid && out_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_out_valid", out_valid, 1'b0);
    send(24'h020000, '0, ONE, ONE);
    drain();

    send(24'h018000, '0, ONE, ONE);
    in_valid = 1'b0;
    acc = exp_q[exp_q.size()-1].acc;
    while (cycle < acc + 10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    seen_first = 0;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cos", cos_th2, '0);
    repeat (30) begin
      @(negedge clk);
      chk("midrst_no_result", out_valid, 1'b0);
    end
    send(24'h010000, 24'h010000, 24'h008000, ONE);
    drain();

    for (int i = 0; i < 70; i++) begin
      or_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        x = W'($urandom);
        y = W'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        x = rnd_signed(8 * 65536);
        y = rnd_signed(8 * 65536);
        a = rnd_pos(4 * 65536);
        b = rnd_pos(4 * 65536);
        if ($urandom_range(0, 9) == 0) a = '0;
        if ($urandom_range(0, 9) == 0) b = '0;
      end
      send(x, y, a, b);
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    or_mode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
